sipo_framer: RTL

Framed serial-to-parallel deserializer, the parametrised successor of the single-word shift-in block. Assembles a gated bit stream into SYM_W-bit symbols, tracks codeword boundaries (FRAME_SYMS symbols per frame) and delivers symbols with first/last tags through a DEPTH-entry valid/ready output FIFO. It sits between the serial line receiver and the Reed-Solomon decoder input.

---
 rtl/sipo_framer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sipo_framer.sv
// sipo_framer: framed serial-to-parallel deserializer with a tagged valid/ready output FIFO.
//
// Assembles a gated bit stream into SYM_W-bit symbols, tags each one with its
// frame position (first/last) and queues it in a DEPTH-entry first-word-fall-through FIFO.
//
// Parameters
//   SYM_W      symbol width in bits (>=2)
//   FRAME_SYMS symbols per frame (>=2)
//   DEPTH      FIFO entries (power of 2, >=2)
//   MSB_FIRST  1: first received bit lands in sym_data[SYM_W-1]; 0: in sym_data[0]
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   bit_in         serial data, sampled when bit_valid=1
//   bit_valid      bit qualifier
//   sof            with bit_valid, marks bit_in as bit 0 of symbol 0
//   ovf_clr        synchronous clear of overflow
//   sym_data       FIFO head symbol
//   sym_first      head symbol is symbol 0 of its frame
//   sym_last       head symbol is symbol FRAME_SYMS-1
//   sym_valid      FIFO not empty
//   sym_ready      consumer accepts the head symbol
//   overflow       sticky: a symbol was dropped on a full FIFO
//   frame_abort    one-cycle pulse: a running frame was restarted by sof
//   frames_done    completed frames pushed (saturating)
//   drop_cnt       dropped symbols (saturating)
//
// Optional feature: define SIPO_FRAMER_STATS_EN to build frames_done/drop_cnt;
// otherwise both ports are tied to zero.
module sipo_framer #(
    parameter int SYM_W      = 8,
    parameter int FRAME_SYMS = 255,
    parameter int DEPTH      = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sof,
    input  logic             ovf_clr,
    output logic [SYM_W-1:0] sym_data,
    output logic             sym_first,
    output logic             sym_last,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             overflow,
    output logic             frame_abort,
    output logic [15:0]      frames_done,
    output logic [15:0]      drop_cnt
);
    localparam int BW = $clog2(SYM_W);
    localparam int SW = $clog2(FRAME_SYMS);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = SYM_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

    state_t            state, state_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [SW-1:0]     sym_cnt, sym_cnt_n;
    logic [SYM_W-1:0]  shreg, shreg_n;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              start, abort, complete, last, full, pop, drop, push;

    assign sym_valid = count != '0;
    assign {sym_data, sym_first, sym_last} = sym_valid ? mem[rd_ptr] : '0;

    always_comb begin
        shreg_n   = MSB_FIRST ? {shreg[SYM_W-2:0], bit_in} : {bit_in, shreg[SYM_W-1:1]};
        start     = bit_valid & sof;
        abort     = start & (state == RUN);
        // sof never completes a symbol: a restart always wins over completion
        complete  = bit_valid & ~sof & (state == RUN) & (bit_cnt == BW'(SYM_W - 1));
        last      = sym_cnt == SW'(FRAME_SYMS - 1);
        full      = count == (AW + 1)'(DEPTH);
        pop       = sym_valid & sym_ready;
        drop      = complete & full & ~pop;
        push      = complete & ~drop;
        state_n   = state;
        bit_cnt_n = bit_cnt;
        sym_cnt_n = sym_cnt;
        if (start) begin
            state_n   = RUN;
            bit_cnt_n = BW'(1);
            sym_cnt_n = '0;
        end else if (complete) begin
            bit_cnt_n = '0;
            sym_cnt_n = (drop | last) ? '0 : sym_cnt + 1'b1;
            state_n   = drop ? DROP : last ? IDLE : RUN;
        end else if (bit_valid && state == RUN) begin
            bit_cnt_n = bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            sym_cnt     <= '0;
            shreg       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            sym_cnt     <= sym_cnt_n;
            if (bit_valid) shreg <= shreg_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count       <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            overflow    <= drop | (overflow & ~ovf_clr);
            frame_abort <= abort;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {shreg_n, sym_cnt == '0, last};
    end

`ifdef SIPO_FRAMER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_done <= '0;
            drop_cnt    <= '0;
        end else begin
            if (push && last && frames_done != 16'hFFFF) frames_done <= frames_done + 16'd1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign frames_done = 16'h0000;
    assign drop_cnt    = 16'h0000;
`endif

endmodule
